// File: rtl/mips_defs.sv
// Shared definitions for the 8-bit multicycle MIPS controller: opcodes,
// state encodings, mux-select codes and the decoded control word.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] S_FETCH1  = 4'd0;
    localparam logic [3:0] S_FETCH2  = 4'd1;
    localparam logic [3:0] S_FETCH3  = 4'd2;
    localparam logic [3:0] S_FETCH4  = 4'd3;
    localparam logic [3:0] S_DECODE  = 4'd4;
    localparam logic [3:0] S_MEMADR  = 4'd5;
    localparam logic [3:0] S_LBRD    = 4'd6;
    localparam logic [3:0] S_LBWR    = 4'd7;
    localparam logic [3:0] S_SBWR    = 4'd8;
    localparam logic [3:0] S_RTYPEEX = 4'd9;
    localparam logic [3:0] S_RTYPEWR = 4'd10;
    localparam logic [3:0] S_BEQEX   = 4'd11;
    localparam logic [3:0] S_JEX     = 4'd12;
    localparam logic [3:0] S_ADDIEX  = 4'd13;
    localparam logic [3:0] S_ADDIWR  = 4'd14;

    localparam logic [1:0] PCSRC_PLUS1  = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUSRCB_B     = 2'b00;
    localparam logic [1:0] ALUSRCB_ONE   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic       memtoreg;
        logic       iord;
        logic       regwrite;
        logic       regdst;
        logic       pcwrite;
        logic       pcwritecond;
        logic [3:0] irwrite;
        logic [1:0] pcsrc;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Purpose: combinational state -> control-word decoder (Moore outputs).
// Latency: zero cycles, purely combinational.
// Backpressure: none; consumes only the current state code.
module mips_ctrl_outdec
    import mips_defs::*;
(
    input  logic [3:0] state,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = ALUSRCB_ONE;
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = PCSRC_PLUS1;
                // Byte lane of the instruction register follows the fetch index.
                ctrl.irwrite = 4'b0001 << state[1:0];
            end
            S_DECODE: begin
                ctrl.alusrcb = ALUSRCB_IMMSH;
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
            end
            S_LBRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_LBWR: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_SBWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWR: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alusrca     = 1'b1;
                ctrl.aluop       = ALUOP_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsrc       = PCSRC_ALUOUT;
            end
            S_JEX: begin
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = ALUSRCB_IMM;
            end
            S_ADDIWR: begin
                ctrl.regwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_control_fsm.sv
// Purpose: multicycle main controller sequencing fetch/decode/execute/mem/writeback.
// Latency: Moore outputs one state per cycle; pcen is combinational in zero.
// Backpressure: none; the sequence free-runs, rst_n abandons the current instruction.
module mips_control_fsm
    import mips_defs::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic       memtoreg,
    output logic       iord,
    output logic       regwrite,
    output logic       regdst,
    output logic       pcen,
    output logic [3:0] irwrite,
    output logic [1:0] pcsrc,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop
);

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       out_en;
    ctrl_t      ctrl;
    ctrl_t      ctrl_gated;

    // out_en clears asynchronously with reset and sets on the first edge after
    // release; the state holds at FETCH1 until then so FETCH1 is seen in full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_FETCH1;
            out_en <= 1'b0;
        end else begin
            out_en <= 1'b1;
            if (out_en) begin
                state <= state_nxt;
            end
        end
    end

    always_comb begin
        state_nxt = S_FETCH1;
        case (state)
            S_FETCH1: state_nxt = S_FETCH2;
            S_FETCH2: state_nxt = S_FETCH3;
            S_FETCH3: state_nxt = S_FETCH4;
            S_FETCH4: state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_RTYPEEX;
                    OP_BEQ:       state_nxt = S_BEQEX;
                    OP_J:         state_nxt = S_JEX;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    default:      state_nxt = S_FETCH1;
                endcase
            end
            S_MEMADR:  state_nxt = (op == OP_LB) ? S_LBRD : S_SBWR;
            S_LBRD:    state_nxt = S_LBWR;
            S_RTYPEEX: state_nxt = S_RTYPEWR;
            S_ADDIEX:  state_nxt = S_ADDIWR;
            default:   state_nxt = S_FETCH1;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state (state),
        .ctrl  (ctrl)
    );

    assign ctrl_gated = out_en ? ctrl : '0;

    assign memread  = ctrl_gated.memread;
    assign memwrite = ctrl_gated.memwrite;
    assign alusrca  = ctrl_gated.alusrca;
    assign memtoreg = ctrl_gated.memtoreg;
    assign iord     = ctrl_gated.iord;
    assign regwrite = ctrl_gated.regwrite;
    assign regdst   = ctrl_gated.regdst;
    assign irwrite  = ctrl_gated.irwrite;
    assign pcsrc    = ctrl_gated.pcsrc;
    assign alusrcb  = ctrl_gated.alusrcb;
    assign aluop    = ctrl_gated.aluop;
    assign pcen     = ctrl_gated.pcwrite | (ctrl_gated.pcwritecond & zero);

endmodule

// File: tb/tb_mips_control_fsm.sv
// Table-driven bench for mips_control_fsm with a per-cycle expected-value queue.
module tb_mips_control_fsm;
    import mips_defs::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, pcen;
    logic [3:0] irwrite;
    logic [1:0] pcsrc, alusrcb, aluop;

    int n_checks = 0;
    int n_pass   = 0;
    logic [17:0] exp_q[$];

    mips_control_fsm dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (op),
        .zero     (zero),
        .memread  (memread),
        .memwrite (memwrite),
        .alusrca  (alusrca),
        .memtoreg (memtoreg),
        .iord     (iord),
        .regwrite (regwrite),
        .regdst   (regdst),
        .pcen     (pcen),
        .irwrite  (irwrite),
        .pcsrc    (pcsrc),
        .alusrcb  (alusrcb),
        .aluop    (aluop)
    );

    always #5 clk = ~clk;

    logic [17:0] got;
    assign got = {memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, pcen,
                  irwrite, pcsrc, alusrcb, aluop};

    // Field order: mr mw asa mtr iord rw rd pcen | irwrite pcsrc alusrcb aluop
    function automatic logic [17:0] w(bit mr, bit mw, bit asa, bit mtr, bit io, bit rw,
                                      bit rd, bit pe, logic [3:0] irw, logic [1:0] ps,
                                      logic [1:0] asb, logic [1:0] aop);
        return {mr, mw, asa, mtr, io, rw, rd, pe, irw, ps, asb, aop};
    endfunction

    function automatic logic [17:0] fetch_exp(int c);
        logic [3:0] irw;
        irw = 4'b0001 << (c - 1);
        if (c <= 4) return w(1,0,0,0,0,0,0,1, irw, 2'b00, 2'b01, 2'b00);
        return w(0,0,0,0,0,0,0,0, 4'b0000, 2'b00, 2'b11, 2'b00);
    endfunction

    typedef struct {
        string       name;
        logic [5:0]  opc;
        logic        z;
        int          len;
        logic [17:0] e6;
        logic [17:0] e7;
        logic [17:0] e8;
    } vec_t;

    vec_t vecs[8];

    task automatic compare(input string name);
        logic [17:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e || (memread && memwrite)) begin
            $display("FAIL %s: got %b required %b", name, got, e);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step(input logic [5:0] op_v, input logic z_v, input logic [17:0] e,
                        input string name);
        @(posedge clk);
        #1;
        op   = op_v;
        zero = z_v;
        exp_q.push_back(e);
        @(negedge clk);
        compare(name);
    endtask

    // Fetch and decode cycles with random op/zero while op is don't-care.
    task automatic front_end(input logic [5:0] opc, input string name);
        for (int c = 1; c <= 5; c++) begin
            step((c == 5) ? opc : 6'($urandom), 1'($urandom),
                 fetch_exp(c), $sformatf("%s_c%0d", name, c));
        end
    endtask

    task automatic run_vec(input vec_t v);
        front_end(v.opc, v.name);
        for (int c = 6; c <= v.len; c++) begin
            step(v.opc, v.z, (c == 6) ? v.e6 : (c == 7) ? v.e7 : v.e8,
                 $sformatf("%s_c%0d", v.name, c));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] memadr_w;
        memadr_w = w(0,0,1,0,0,0,0,0, 4'b0000, 2'b00, 2'b10, 2'b00);
        vecs[0] = '{"lb",    OP_LB,    1'b0, 8, memadr_w,
                    w(1,0,0,0,1,0,0,0, 4'b0000, 2'b00, 2'b00, 2'b00),
                    w(0,0,0,1,0,1,0,0, 4'b0000, 2'b00, 2'b00, 2'b00)};
        vecs[1] = '{"sb",    OP_SB,    1'b1, 7, memadr_w,
                    w(0,1,0,0,1,0,0,0, 4'b0000, 2'b00, 2'b00, 2'b00), '0};
        vecs[2] = '{"beq_z1", OP_BEQ,  1'b1, 6,
                    w(0,0,1,0,0,0,0,1, 4'b0000, 2'b01, 2'b00, 2'b01), '0, '0};
        vecs[3] = '{"beq_z0", OP_BEQ,  1'b0, 6,
                    w(0,0,1,0,0,0,0,0, 4'b0000, 2'b01, 2'b00, 2'b01), '0, '0};
        vecs[4] = '{"j",     OP_J,     1'b0, 6,
                    w(0,0,0,0,0,0,0,1, 4'b0000, 2'b10, 2'b00, 2'b00), '0, '0};
        vecs[5] = '{"rtype", OP_RTYPE, 1'b1, 7,
                    w(0,0,1,0,0,0,0,0, 4'b0000, 2'b00, 2'b00, 2'b10),
                    w(0,0,0,0,0,1,1,0, 4'b0000, 2'b00, 2'b00, 2'b00), '0};
        vecs[6] = '{"addi",  OP_ADDI,  1'b0, 7, memadr_w,
                    w(0,0,0,0,0,1,0,0, 4'b0000, 2'b00, 2'b00, 2'b00), '0};
        vecs[7] = '{"illegal", 6'b111111, 1'b1, 5, '0, '0, '0};

        // Reset held for three cycles: every output must read zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op = 6'($urandom);
            zero = 1'b1;
            exp_q.push_back('0);
            #1;
            compare($sformatf("reset_c%0d", i));
        end
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // BEQ with zero toggling inside BEQEX: pcen follows within the cycle.
        front_end(OP_BEQ, "beq_tog");
        @(posedge clk);
        #1;
        op = OP_BEQ;
        zero = 1'b0;
        #2;
        exp_q.push_back(w(0,0,1,0,0,0,0,0, 4'b0000, 2'b01, 2'b00, 2'b01));
        compare("beq_tog_z0");
        zero = 1'b1;
        #1;
        exp_q.push_back(w(0,0,1,0,0,0,0,1, 4'b0000, 2'b01, 2'b00, 2'b01));
        compare("beq_tog_z1");

        // Reset pulse during LBRD: outputs clear at once, no LBWR afterwards.
        front_end(OP_LB, "lb_rst");
        step(OP_LB, 1'b0, w(0,0,1,0,0,0,0,0, 4'b0000, 2'b00, 2'b10, 2'b00), "lb_rst_c6");
        @(posedge clk);
        #1;
        op = OP_LB;
        exp_q.push_back(w(1,0,0,0,1,0,0,0, 4'b0000, 2'b00, 2'b00, 2'b00));
        #1;
        compare("lb_rst_lbrd");
        rst_n = 1'b0;
        #1;
        exp_q.push_back('0);
        compare("lb_rst_during");
        #4;
        rst_n = 1'b1;
        step(OP_LB, 1'b0, fetch_exp(1), "lb_rst_after_c1");
        step(OP_LB, 1'b0, fetch_exp(2), "lb_rst_after_c2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
